// File: rtl/timer_prescaler_if.sv
// Control/status bundle between the timer
// register block and the count-clock prescaler.
interface timer_prescaler_if #(
  parameter int DIV_W = 4,
  parameter int CKS_W = 2
);
  logic             en;
  logic [CKS_W-1:0] cks;
  logic             presc_clr;
  logic             clk_in;
  logic [DIV_W-1:0] div_cnt;

  modport master (
    output en,
    output cks,
    output presc_clr,
    input  clk_in,
    input  div_cnt
  );

  modport slave (
    input  en,
    input  cks,
    input  presc_clr,
    output clk_in,
    output div_cnt
  );
endinterface

// File: rtl/timer_prescaler.sv
// Count-enable generator for the 8-bit timer:
// divides pclk by 2**(cks+1) into a 1-cycle pulse.
module timer_prescaler #(
  parameter int DIV_W = 4,
  parameter int CKS_W = 2
) (
  input  logic         pclk,
  input  logic         presetn,
  timer_prescaler_if.slave bus
);

  localparam logic [DIV_W-1:0] ONE =
    {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] mask;
  logic             term;
  logic             tick;

  // Compare only bits [cks:0]; upper bits are don't-care.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DIV_W; i++) begin
      mask[i] = (i <= int'(bus.cks));
    end
  end

  assign term = bus.en
              & ~bus.presc_clr
              & ((cnt & mask) == mask);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= term;
      if (bus.presc_clr || !bus.en) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

  assign bus.clk_in  = tick;
  assign bus.div_cnt = cnt;

endmodule

// File: tb/tb_timer_prescaler.sv
// Directed bench for timer_prescaler: period
// table plus enable/clear/cks-switch/reset cases.
module tb_timer_prescaler;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  logic prev_ck = 1'b0;

  always #5 pclk = ~pclk;

  timer_prescaler_if #(.DIV_W(4), .CKS_W(2)) tif ();

  timer_prescaler #(.DIV_W(4), .CKS_W(2)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (tif)
  );

  typedef struct {
    logic [1:0] cks;
    int         cycles;
    int         pulses;
    int         first;
    int         spacing;
    int         div;
  } vec_t;

  vec_t vecs[7];

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  task automatic step();
    prev_ck = tif.clk_in;
    @(posedge pclk);
    #1;
  endtask

  // Edge sampled with en=0 leaves div_cnt=0; en is
  // then raised so the next edge counts as n=1.
  task automatic arm(input logic [1:0] k);
    tif.en        = 1'b0;
    tif.presc_clr = 1'b0;
    tif.cks       = k;
    step();
    tif.en = 1'b1;
  endtask

  task automatic run_seg(input  logic [1:0] k,
                         input  int ncyc,
                         output int np,
                         output int first,
                         output int mn,
                         output int mx,
                         output int dbl);
    int last;
    arm(k);
    np = 0; first = 0; last = 0;
    mn = 1 << 30; mx = 0; dbl = 0;
    for (int n = 1; n <= ncyc; n++) begin
      step();
      if (tif.clk_in) begin
        if (prev_ck) dbl++;
        if (np == 0) first = n;
        else begin
          if (n - last < mn) mn = n - last;
          if (n - last > mx) mx = n - last;
        end
        last = n;
        np++;
      end
    end
  endtask

  initial begin
    int np, first, mn, mx, dbl;
    int cnt, pos1, pos2;
    string s;

    vecs[0] = '{2'd2, 2048, 256,  8,  8,  0};
    vecs[1] = '{2'd2, 2000, 250,  8,  8,  0};
    vecs[2] = '{2'd0,  256, 128,  2,  2,  0};
    vecs[3] = '{2'd1,  256,  64,  4,  4,  0};
    vecs[4] = '{2'd3,  256,  16, 16, 16,  0};
    vecs[5] = '{2'd1,   10,   2,  4,  4, 10};
    vecs[6] = '{2'd3,   21,   1, 16, 16,  5};

    // T1: reset held while inputs wiggle
    tif.en = 1'b1;
    tif.cks = 2'd3;
    tif.presc_clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tif.en = ~tif.en;
      tif.presc_clr = i[1];
      step();
      chk("rst_clk_in", int'(tif.clk_in), 0);
      chk("rst_div", int'(tif.div_cnt), 0);
    end
    tif.en = 1'b0;
    tif.presc_clr = 1'b0;
    presetn = 1'b1;

    // T2/T3: period table
    foreach (vecs[i]) begin
      run_seg(vecs[i].cks, vecs[i].cycles,
              np, first, mn, mx, dbl);
      s = $sformatf("v%0d", i);
      chk({s, "_pulses"}, np, vecs[i].pulses);
      chk({s, "_first"}, first, vecs[i].first);
      chk({s, "_double"}, dbl, 0);
      chk({s, "_div"}, int'(tif.div_cnt),
          vecs[i].div);
      if (np >= 2) begin
        chk({s, "_minsp"}, mn, vecs[i].spacing);
        chk({s, "_maxsp"}, mx, vecs[i].spacing);
      end
    end

    // T4: enable gate
    arm(2'd1);
    cnt = 0;
    for (int n = 1; n <= 6; n++) begin
      step();
      if (tif.clk_in) cnt++;
    end
    tif.en = 1'b0;
    pos1 = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (tif.clk_in) cnt++;
      if (tif.div_cnt != 4'd0) pos1++;
    end
    chk("en_pulses", cnt, 1);
    chk("en_div_nonzero", pos1, 0);
    tif.en = 1'b1;
    first = 0;
    for (int n = 1; n <= 6; n++) begin
      step();
      if (tif.clk_in && first == 0) first = n;
    end
    chk("reen_first", first, 4);

    // T5: clear at div_cnt=5
    arm(2'd2);
    for (int n = 1; n <= 5; n++) step();
    chk("clr_pre_div", int'(tif.div_cnt), 5);
    tif.presc_clr = 1'b1;
    step();
    tif.presc_clr = 1'b0;
    chk("clr_div", int'(tif.div_cnt), 0);
    chk("clr_tick", int'(tif.clk_in), 0);
    cnt = 0; first = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (tif.clk_in) begin
        cnt++;
        if (first == 0) first = n;
      end
    end
    chk("clr_pulses", cnt, 1);
    chk("clr_first", first, 8);

    // T6: cks 10->00 at 3, 00->11 at 6
    arm(2'd2);
    for (int n = 1; n <= 3; n++) step();
    chk("sw_div3", int'(tif.div_cnt), 3);
    tif.cks = 2'd0;
    step();
    chk("sw0_e1", int'(tif.clk_in), 1);
    step();
    chk("sw0_e2", int'(tif.clk_in), 0);
    step();
    chk("sw0_e3", int'(tif.clk_in), 1);
    chk("sw_div6", int'(tif.div_cnt), 6);
    tif.cks = 2'd3;
    pos1 = 0; pos2 = 0; dbl = 0;
    for (int n = 1; n <= 26; n++) begin
      step();
      if (tif.clk_in) begin
        if (prev_ck) dbl++;
        if (pos1 == 0) pos1 = n;
        else if (pos2 == 0) pos2 = n;
      end
    end
    chk("sw3_first", pos1, 10);
    chk("sw3_second", pos2, 26);
    chk("sw3_double", dbl, 0);

    // async reset while the pulse is high
    presetn = 1'b0;
    #1;
    chk("arst_clk_in", int'(tif.clk_in), 0);
    chk("arst_div", int'(tif.div_cnt), 0);
    step();
    presetn = 1'b1;
    first = 0;
    for (int n = 1; n <= 18; n++) begin
      step();
      if (tif.clk_in && first == 0) first = n;
    end
    chk("arst_first", first, 16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
